// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter request front end.
// Holds the requester count and the per-channel FSM state encoding.
package rr_arb_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } ch_state_e;

endpackage

// File: rtl/rr_req_chan.sv
// One request channel: payload FIFO, req/grant FSM and grant-window counter.
// Ports: push_i/data_i in, gnt_i/block_i from grant decode, ready_o/req_o/
// win_o/pop_o/head_o out; retry_cnt_o only with RR_REQ_QUEUE_STATS_EN.
module rr_req_chan
    import rr_arb_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int REQ2GNT = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          gnt_i,
    input  logic          block_i,
    output logic          ready_o,
    output logic          req_o,
    output logic          win_o,
    output logic          pop_o,
    output logic [DW-1:0] head_o
`ifdef RR_REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]   retry_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(REQ2GNT + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, rd_q, occ;
    logic [CW-1:0] cnt_q, cnt_d;
    ch_state_e     state_q, state_d;
    logic          empty, full, push, more;

    assign occ   = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push  = push_i && !full;

    assign ready_o = !full;
    assign req_o   = (state_q == REQ);
    // Only the last wait cycle samples the grant.
    assign win_o   = (state_q == WAIT) && (cnt_q == CW'(1));
    assign pop_o   = win_o && gnt_i && !block_i;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    // Entries left once the head is popped, counting a same-cycle push.
    assign more    = (occ > (AW+1)'(1)) || push;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!empty || push) state_d = REQ;
            end
            REQ: begin
                cnt_d   = CW'(REQ2GNT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (win_o) state_d = (pop_o && !more) ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (push)  wr_q <= wr_q + 1'b1;
            if (pop_o) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

`ifdef RR_REQ_QUEUE_STATS_EN
    logic [15:0] retry_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            retry_q <= '0;
        end else if (win_o && !gnt_i && retry_q != 16'hFFFF) begin
            retry_q <= retry_q + 16'd1;
        end
    end

    assign retry_cnt_o = retry_q;
`endif

endmodule

// File: rtl/rr_req_queue.sv
// Request front end for the 3-way arbiter: per-channel FIFOs, grant
// matching, tagged output register and sticky stray/multi grant flags.
// Ports: in_valid/in_data/in_ready, req1..3, gnt1..3, out_valid/out_data/
// out_id, err_stray_gnt, err_multi_gnt; retry_cnt1..3 with
// RR_REQ_QUEUE_STATS_EN defined.
module rr_req_queue
    import rr_arb_pkg::*;
#(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int REQ2GNT = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         in_valid,
    input  logic [NUM_REQ-1:0][DW-1:0] in_data,
    output logic [NUM_REQ-1:0]         in_ready,
    output logic                       req1,
    output logic                       req2,
    output logic                       req3,
    input  logic                       gnt1,
    input  logic                       gnt2,
    input  logic                       gnt3,
    output logic                       out_valid,
    output logic [DW-1:0]              out_data,
    output logic [1:0]                 out_id,
    output logic                       err_stray_gnt,
    output logic                       err_multi_gnt
`ifdef RR_REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]                retry_cnt1,
    output logic [15:0]                retry_cnt2,
    output logic [15:0]                retry_cnt3
`endif
);

    logic [NUM_REQ-1:0]         gnt_v, req_v, win_v, pop_v;
    logic [NUM_REQ-1:0][DW-1:0] head_v;
    logic                       multi, stray;
    logic                       out_valid_q, err_stray_q, err_multi_q;
    logic [DW-1:0]              out_data_q, sel_data;
    logic [1:0]                 out_id_q, sel_id;
`ifdef RR_REQ_QUEUE_STATS_EN
    logic [NUM_REQ-1:0][15:0]   retry_v;
`endif

    assign gnt_v = {gnt3, gnt2, gnt1};
    assign multi = (gnt_v[0] & gnt_v[1]) |
                   (gnt_v[0] & gnt_v[2]) |
                   (gnt_v[1] & gnt_v[2]);
    assign stray = |(gnt_v & ~win_v);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
        rr_req_chan #(
            .DW      (DW),
            .DEPTH   (DEPTH),
            .REQ2GNT (REQ2GNT)
        ) u_chan (
            .clk         (clk),
            .resetn      (resetn),
            .push_i      (in_valid[i]),
            .data_i      (in_data[i]),
            .gnt_i       (gnt_v[i]),
            .block_i     (multi),
            .ready_o     (in_ready[i]),
            .req_o       (req_v[i]),
            .win_o       (win_v[i]),
            .pop_o       (pop_v[i]),
            .head_o      (head_v[i])
`ifdef RR_REQ_QUEUE_STATS_EN
            ,
            .retry_cnt_o (retry_v[i])
`endif
        );
    end

    // Multi-grant blocks every pop, so at most one bit of pop_v is set.
    always_comb begin
        sel_id   = 2'd0;
        sel_data = '0;
        unique case (1'b1)
            pop_v[0]: begin sel_id = 2'd1; sel_data = head_v[0]; end
            pop_v[1]: begin sel_id = 2'd2; sel_data = head_v[1]; end
            pop_v[2]: begin sel_id = 2'd3; sel_data = head_v[2]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 2'd0;
            err_stray_q <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            out_valid_q <= |pop_v;
            if (|pop_v) begin
                out_data_q <= sel_data;
                out_id_q   <= sel_id;
            end
            err_stray_q <= err_stray_q | stray;
            err_multi_q <= err_multi_q | multi;
        end
    end

    assign req1          = req_v[0];
    assign req2          = req_v[1];
    assign req3          = req_v[2];
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_id        = out_id_q;
    assign err_stray_gnt = err_stray_q;
    assign err_multi_gnt = err_multi_q;

`ifdef RR_REQ_QUEUE_STATS_EN
    assign retry_cnt1 = retry_v[0];
    assign retry_cnt2 = retry_v[1];
    assign retry_cnt3 = retry_v[2];
`endif

endmodule

// File: tb/tb_rr_req_queue.sv
// Directed bench for rr_req_queue acting as the arbiter side.
// Expected outputs are queued when a grant is driven and checked on out_valid.
module tb_rr_req_queue;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int R = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [2:0]        in_valid;
    logic [2:0][DW-1:0] in_data;
    logic [2:0]        in_ready;
    logic              req1, req2, req3;
    logic [2:0]        gv;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_id;
    logic              err_stray_gnt, err_multi_gnt;
`ifdef RR_REQ_QUEUE_STATS_EN
    logic [15:0]       retry_cnt1, retry_cnt2, retry_cnt3;
`endif

    logic [2:0]        reqv;
    assign reqv = {req3, req2, req1};

    rr_req_queue #(.DW(DW), .DEPTH(DEPTH), .REQ2GNT(R)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .req1          (req1),
        .req2          (req2),
        .req3          (req3),
        .gnt1          (gv[0]),
        .gnt2          (gv[1]),
        .gnt3          (gv[2]),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_id        (out_id),
        .err_stray_gnt (err_stray_gnt),
        .err_multi_gnt (err_multi_gnt)
`ifdef RR_REQ_QUEUE_STATS_EN
        ,
        .retry_cnt1    (retry_cnt1),
        .retry_cnt2    (retry_cnt2),
        .retry_cnt3    (retry_cnt3)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [DW+1:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int ch, input logic [DW-1:0] d);
        in_valid[ch-1] = 1'b1;
        in_data[ch-1]  = d;
        step();
        in_valid[ch-1] = 1'b0;
    endtask

    // Returns cycles spent before req was seen; a timeout is a failure.
    task automatic wait_req(input int ch, output int waited);
        waited = 0;
        while (!reqv[ch-1] && waited < 20) begin
            step();
            waited++;
        end
        chk("req_seen", reqv[ch-1], 1);
    endtask

    // Called at the REQ cycle; drives the grant in the sampling cycle.
    task automatic grant(input int ch, input bit give,
                         input logic [DW-1:0] d);
        logic [DW+1:0] e;
        repeat (R) step();
        gv[ch-1] = give;
        if (give) sb.push_back({2'(ch), d});
        step();
        gv[ch-1] = 1'b0;
        if (give) begin
            chk("out_valid", out_valid, 1);
            if (out_valid && sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_data", out_data, e[DW-1:0]);
                chk("out_id", out_id, e[DW+1:DW]);
            end
        end else begin
            chk("no_out_on_retry", out_valid, 0);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", reqv, 3'b000);
        chk("rst_ready", in_ready, 3'b111);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_oid", out_id, 0);
        chk("rst_stray", err_stray_gnt, 0);
        chk("rst_multi", err_multi_gnt, 0);
    endtask

    initial begin
        int w;
        int pulses;
        logic seen;

        resetn   = 1'b0;
        in_valid = '0;
        in_data  = '0;
        gv       = '0;
        repeat (3) step();
        chk_reset_vals();
        resetn = 1'b1;
        repeat (2) step();

        // Single entry on channel 2 with exact req timing.
        push(2, 8'hA5);
        chk("t1_req", reqv, 3'b010);
        grant(2, 1'b1, 8'hA5);
        chk("t1_no_err", {err_stray_gnt, err_multi_gnt}, 2'b00);
        repeat (3) step();

        // Fill channel 1, then grant back to back.
        push(1, 8'h11);
        push(1, 8'h22);
        push(1, 8'h33);
        chk("t2_ready_before_full", in_ready[0], 1);
        push(1, 8'h44);
        chk("t2_ready_full", in_ready[0], 0);
        wait_req(1, w);
        grant(1, 1'b1, 8'h11);
        chk("t2_ready_after_pop", in_ready[0], 1);
        wait_req(1, w);
        chk("t2_spacing1", w, 0);
        grant(1, 1'b1, 8'h22);
        wait_req(1, w);
        chk("t2_spacing2", w, 0);
        grant(1, 1'b1, 8'h33);
        wait_req(1, w);
        chk("t2_spacing3", w, 0);
        grant(1, 1'b1, 8'h44);
        seen = 1'b0;
        repeat (8) begin
            step();
            seen = seen | req1;
        end
        chk("t2_req1_quiet", seen, 0);

        // Two withheld grants on channel 3, then grant.
        pulses = 0;
        push(3, 8'h5C);
        wait_req(3, w);
        pulses++;
        grant(3, 1'b0, 8'h00);
        wait_req(3, w);
        chk("t3_retry_gap1", w, 0);
        pulses++;
        grant(3, 1'b0, 8'h00);
        wait_req(3, w);
        chk("t3_retry_gap2", w, 0);
        pulses++;
        grant(3, 1'b1, 8'h5C);
        chk("t3_pulses", pulses, 3);
`ifdef RR_REQ_QUEUE_STATS_EN
        chk("t3_retry_cnt3", retry_cnt3, 16'd2);
`endif
        repeat (3) step();

        // Simultaneous grants to channels 1 and 2.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h71;
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h72;
        step();
        in_valid = '0;
        chk("t4_req_both", reqv, 3'b011);
        repeat (R) step();
        gv = 3'b011;
        step();
        gv = '0;
        chk("t4_no_out", out_valid, 0);
        chk("t4_multi", err_multi_gnt, 1);
        chk("t4_no_stray", err_stray_gnt, 0);
        chk("t4_rereq", reqv, 3'b011);
        grant(1, 1'b1, 8'h71);
        wait_req(2, w);
        chk("t4_ch2_retry_gap", w, 0);
        grant(2, 1'b1, 8'h72);
        repeat (3) step();

        // Grant to an empty channel.
        chk("t5_stray_pre", err_stray_gnt, 0);
        gv[1] = 1'b1;
        step();
        gv[1] = 1'b0;
        chk("t5_stray", err_stray_gnt, 1);
        chk("t5_no_out", out_valid, 0);
        step();
        chk("t5_no_out_late", out_valid, 0);

        // Reset while channel 1 holds two entries in WAIT.
        push(1, 8'h81);
        push(1, 8'h82);
        chk("t6_in_wait", req1, 0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk_reset_vals();
        gv[0] = 1'b1;
        step();
        gv[0] = 1'b0;
        chk("t6_stray_after_rst", err_stray_gnt, 1);
        chk("t6_no_out", out_valid, 0);
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | req1 | out_valid;
        end
        chk("t6_discarded", seen, 0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
